exception_unit: RTL and testbench

Parametrised, registered exception/ERET commit unit for the N-issue MIPS32r1 pipeline, sitting between the memory stage and CP0/fetch. Each cycle it selects the oldest excepting lane among LANES commit slots using a fixed cause priority, then kills younger lanes. It issues a one-cycle CP0 update and sequences a pipeline flush plus a ready/valid fetch redirect through a small state machine.

---
 rtl/exception_pkg.sv | 46 ++++
 rtl/exception_lane_prio.sv | 60 ++++++
 rtl/exception_unit.sv | 175 +++++++++++++++++
 tb/tb_exception_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exception_pkg.sv
// Shared constants for the exception/ERET commit unit: cause bit layout,
// ExcCode values, vector offsets and the FSM state encoding.
package exception_pkg;

    localparam int NCAUSE = 13;

    localparam int CAUSE_ADEL_IF      = 0;
    localparam int CAUSE_ITLB_REFILL  = 1;
    localparam int CAUSE_ITLB_INVALID = 2;
    localparam int CAUSE_SYS          = 3;
    localparam int CAUSE_BP           = 4;
    localparam int CAUSE_RI           = 5;
    localparam int CAUSE_CPU          = 6;
    localparam int CAUSE_OV           = 7;
    localparam int CAUSE_ERET         = 8;
    localparam int CAUSE_ADE_DATA     = 9;
    localparam int CAUSE_DTLB_REFILL  = 10;
    localparam int CAUSE_DTLB_INVALID = 11;
    localparam int CAUSE_MOD          = 12;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_MOD  = 5'h01,
        EXC_TLBL = 5'h02,
        EXC_TLBS = 5'h03,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_CPU  = 5'h0b,
        EXC_OV   = 5'h0c
    } exc_code_e;

    localparam logic [31:0] VEC_REFILL    = 32'h0000_0000;
    localparam logic [31:0] VEC_GENERAL   = 32'h0000_0180;
    localparam logic [31:0] VEC_INTERRUPT = 32'h0000_0200;
    localparam logic [31:0] BEV_BASE      = 32'hBFC0_0200;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

endpackage

// File: rtl/exception_lane_prio.sv
// Per-lane fixed-priority cause encoder: picks the highest-priority cause of
// one commit slot and reports which CP0 side fields it updates.
module exception_lane_prio
    import exception_pkg::*;
(
    input  logic [NCAUSE-1:0] cause,
    input  logic              int_req,
    input  logic              mem_wen,
    output logic              hit,
    output logic              is_int,
    output logic              eret,
    output logic              refill,
    output logic              badv_en,
    output logic              badv_from_pc,
    output logic              asid_en,
    output logic              asid_from_if,
    output logic [4:0]        code
);

    always_comb begin
        hit          = int_req | (|cause);
        is_int       = 1'b0;
        eret         = 1'b0;
        refill       = 1'b0;
        badv_en      = 1'b0;
        badv_from_pc = 1'b0;
        asid_en      = 1'b0;
        asid_from_if = 1'b0;
        code         = EXC_INT;
        if (int_req) begin
            is_int = 1'b1;
        end else if (cause[CAUSE_ADEL_IF]) begin
            code = EXC_ADEL;  badv_en = 1'b1;  badv_from_pc = 1'b1;
        end else if (cause[CAUSE_ITLB_REFILL] || cause[CAUSE_ITLB_INVALID]) begin
            code = EXC_TLBL;  badv_en = 1'b1;  badv_from_pc = 1'b1;
            asid_en = 1'b1;   asid_from_if = 1'b1;
            refill = cause[CAUSE_ITLB_REFILL];
        end else if (cause[CAUSE_SYS]) begin
            code = EXC_SYS;
        end else if (cause[CAUSE_BP]) begin
            code = EXC_BP;
        end else if (cause[CAUSE_RI]) begin
            code = EXC_RI;
        end else if (cause[CAUSE_CPU]) begin
            code = EXC_CPU;
        end else if (cause[CAUSE_OV]) begin
            code = EXC_OV;
        end else if (cause[CAUSE_ERET]) begin
            eret = 1'b1;
        end else if (cause[CAUSE_ADE_DATA]) begin
            code = mem_wen ? EXC_ADES : EXC_ADEL;  badv_en = 1'b1;
        end else if (cause[CAUSE_DTLB_REFILL] || cause[CAUSE_DTLB_INVALID]) begin
            code = mem_wen ? EXC_TLBS : EXC_TLBL;  badv_en = 1'b1;  asid_en = 1'b1;
            refill = cause[CAUSE_DTLB_REFILL];
        end else if (cause[CAUSE_MOD]) begin
            code = EXC_MOD;  badv_en = 1'b1;  asid_en = 1'b1;
        end
    end

endmodule

// File: rtl/exception_unit.sv
// Exception/ERET commit unit: picks the oldest excepting lane, writes CP0 and
// sequences flush then a ready/valid fetch redirect.
//   state       | meaning
//   ST_IDLE     | watching commit lanes, detection allowed
//   ST_FLUSH    | flush held high for FLUSH_CYCLES cycles
//   ST_REDIRECT | redirect_valid held until redirect_ready
module exception_unit
    import exception_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [LANES-1:0]               lane_valid,
    input  logic [LANES-1:0][31:0]         lane_pc,
    input  logic [LANES-1:0]               lane_bd,
    input  logic [LANES-1:0][NCAUSE-1:0]   lane_cause,
    input  logic [LANES-1:0]               lane_mem_wen,
    input  logic [LANES-1:0][31:0]         lane_badaddr,
    input  logic [7:0]                     asid_if,
    input  logic [7:0]                     asid_mem,
    input  logic [7:0]                     int_flag,
    input  logic                           allow_interrupt,
    input  logic                           exl,
    input  logic [31:0]                    cp0_ebase,
    input  logic                           use_iv,
    input  logic                           use_bev,
    input  logic [31:0]                    epc_in,
    input  logic                           redirect_ready,
    output logic [LANES-1:0]               lane_kill,
    output logic                           commit_stall,
    output logic                           flush,
    output logic                           redirect_valid,
    output logic [31:0]                    redirect_pc,
    output logic                           cp0_exp_en,
    output logic                           cp0_exl_clean,
    output logic [4:0]                     cp0_code,
    output logic [31:0]                    cp0_epc,
    output logic                           cp0_bd,
    output logic [31:0]                    cp0_badvaddr,
    output logic                           cp0_badvaddr_wen,
    output logic [7:0]                     cp0_asid,
    output logic                           cp0_asid_en
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e          state, state_next;
    logic [CW-1:0]   cnt;
    logic [7:0]      int_q;
    logic            int_pending;

    logic [LANES-1:0]       p_hit, p_int, p_eret, p_refill;
    logic [LANES-1:0]       p_badv_en, p_badv_pc, p_asid_en, p_asid_if;
    logic [LANES-1:0][4:0]  p_code;

    logic [LW-1:0]   win;
    logic            win_any, detect;
    logic [31:0]     sel_pc, base, vec_off, target;
    logic            unused_ebase;

    assign unused_ebase = ^{cp0_ebase[31:30], cp0_ebase[11:0]};
    assign int_pending  = lane_valid[0] & allow_interrupt & (int_q != 8'h00);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        exception_lane_prio u_prio (
            .cause        (lane_cause[l]),
            .int_req      ((l == 0) ? int_pending : 1'b0),
            .mem_wen      (lane_mem_wen[l]),
            .hit          (p_hit[l]),
            .is_int       (p_int[l]),
            .eret         (p_eret[l]),
            .refill       (p_refill[l]),
            .badv_en      (p_badv_en[l]),
            .badv_from_pc (p_badv_pc[l]),
            .asid_en      (p_asid_en[l]),
            .asid_from_if (p_asid_if[l]),
            .code         (p_code[l])
        );
    end

    // Scan from youngest to oldest so the lowest-index hit wins.
    always_comb begin
        win     = '0;
        win_any = 1'b0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_valid[l] && p_hit[l]) begin
                win     = LW'(l);
                win_any = 1'b1;
            end
        end
    end

    assign detect = (state == ST_IDLE) && win_any;

    always_comb begin
        lane_kill = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_kill[l] = detect && (l >= int'(win));
        end
    end

    always_comb begin
        sel_pc  = lane_pc[win];
        base    = use_bev ? BEV_BASE : {2'b10, cp0_ebase[29:12], 12'h000};
        vec_off = VEC_GENERAL;
        if (p_refill[win] && !exl)
            vec_off = VEC_REFILL;
        else if (p_int[win] && use_iv)
            vec_off = VEC_INTERRUPT;
        target = p_eret[win] ? epc_in : base + vec_off;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (detect)         state_next = ST_FLUSH;
            ST_FLUSH:    if (cnt == '0)      state_next = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ready) state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        commit_stall   = (state != ST_IDLE);
        flush          = (state == ST_FLUSH);
        redirect_valid = (state == ST_REDIRECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int_q            <= '0;
            cnt              <= '0;
            redirect_pc      <= '0;
            cp0_exp_en       <= 1'b0;
            cp0_exl_clean    <= 1'b0;
            cp0_code         <= '0;
            cp0_epc          <= '0;
            cp0_bd           <= 1'b0;
            cp0_badvaddr     <= '0;
            cp0_badvaddr_wen <= 1'b0;
            cp0_asid         <= '0;
            cp0_asid_en      <= 1'b0;
        end else begin
            int_q            <= int_flag;
            cp0_exp_en       <= 1'b0;
            cp0_exl_clean    <= 1'b0;
            cp0_badvaddr_wen <= 1'b0;
            cp0_asid_en      <= 1'b0;
            if (detect) begin
                cnt              <= CW'(FLUSH_CYCLES - 1);
                redirect_pc      <= target;
                cp0_exp_en       <= ~p_eret[win];
                cp0_exl_clean    <= p_eret[win];
                cp0_code         <= p_code[win];
                cp0_epc          <= lane_bd[win] ? sel_pc - 32'd4 : sel_pc;
                cp0_bd           <= lane_bd[win];
                cp0_badvaddr     <= p_badv_pc[win] ? sel_pc : lane_badaddr[win];
                cp0_badvaddr_wen <= p_badv_en[win];
                cp0_asid         <= p_asid_if[win] ? asid_if : asid_mem;
                cp0_asid_en      <= p_asid_en[win];
            end else if (state == ST_FLUSH && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_exception_unit.sv
// Self-checking bench for exception_unit: table of lane scenarios with a
// queue of expected CP0/redirect results, plus interrupt and stall/reset cases.
module tb_exception_unit;
    import exception_pkg::*;

    localparam int LANES = 2;
    localparam int FLUSH = 2;

    typedef struct {
        logic [1:0]        valid;
        logic [31:0]       pc0, pc1;
        logic [1:0]        bd;
        logic [NCAUSE-1:0] c0, c1;
        logic [1:0]        wen;
        logic [31:0]       a0, a1;
        logic              exl, bev;
        logic [31:0]       ebase;
        logic [1:0]        kill;
        logic              eret;
        logic [4:0]        code;
        logic [31:0]       epc;
        logic              ebd;
        logic              bwen;
        logic [31:0]       badv;
        logic              aen;
        logic [7:0]        asid;
        logic [31:0]       rpc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [LANES-1:0]             lane_valid;
    logic [LANES-1:0][31:0]       lane_pc;
    logic [LANES-1:0]             lane_bd;
    logic [LANES-1:0][NCAUSE-1:0] lane_cause;
    logic [LANES-1:0]             lane_mem_wen;
    logic [LANES-1:0][31:0]       lane_badaddr;
    logic [7:0]  asid_if, asid_mem, int_flag;
    logic        allow_interrupt, exl, use_iv, use_bev, redirect_ready;
    logic [31:0] cp0_ebase, epc_in;
    logic [LANES-1:0] lane_kill;
    logic        commit_stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        cp0_exp_en, cp0_exl_clean;
    logic [4:0]  cp0_code;
    logic [31:0] cp0_epc;
    logic        cp0_bd;
    logic [31:0] cp0_badvaddr;
    logic        cp0_badvaddr_wen;
    logic [7:0]  cp0_asid;
    logic        cp0_asid_en;

    int checks = 0;
    int errors = 0;
    vec_t exp_q[$];
    vec_t vecs[$];
    vec_t mon_e;
    bit   prev_pulse = 1'b0;

    exception_unit #(.LANES(LANES), .FLUSH_CYCLES(FLUSH)) dut (
        .clk(clk), .rst(rst),
        .lane_valid(lane_valid), .lane_pc(lane_pc), .lane_bd(lane_bd),
        .lane_cause(lane_cause), .lane_mem_wen(lane_mem_wen), .lane_badaddr(lane_badaddr),
        .asid_if(asid_if), .asid_mem(asid_mem), .int_flag(int_flag),
        .allow_interrupt(allow_interrupt), .exl(exl), .cp0_ebase(cp0_ebase),
        .use_iv(use_iv), .use_bev(use_bev), .epc_in(epc_in), .redirect_ready(redirect_ready),
        .lane_kill(lane_kill), .commit_stall(commit_stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .cp0_exp_en(cp0_exp_en), .cp0_exl_clean(cp0_exl_clean), .cp0_code(cp0_code),
        .cp0_epc(cp0_epc), .cp0_bd(cp0_bd), .cp0_badvaddr(cp0_badvaddr),
        .cp0_badvaddr_wen(cp0_badvaddr_wen), .cp0_asid(cp0_asid), .cp0_asid_en(cp0_asid_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NCAUSE-1:0] cb(input int i);
        logic [NCAUSE-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic vec_t def_vec();
        vec_t v;
        v.valid = 2'b00; v.pc0 = '0; v.pc1 = '0; v.bd = 2'b00;
        v.c0 = '0; v.c1 = '0; v.wen = 2'b00; v.a0 = '0; v.a1 = '0;
        v.exl = 1'b0; v.bev = 1'b0; v.ebase = 32'h8000_0000;
        v.kill = 2'b00; v.eret = 1'b0; v.code = '0; v.epc = '0; v.ebd = 1'b0;
        v.bwen = 1'b0; v.badv = '0; v.aen = 1'b0; v.asid = '0; v.rpc = 32'h8000_0180;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_kill"}, lane_kill, 0);
        chk({tag, "_state"}, {commit_stall, flush, redirect_valid}, 0);
        chk({tag, "_rpc"}, redirect_pc, 0);
        chk({tag, "_pulses"}, {cp0_exp_en, cp0_exl_clean, cp0_badvaddr_wen, cp0_asid_en}, 0);
        chk({tag, "_code_bd_asid"}, {cp0_code, cp0_bd, cp0_asid}, 0);
        chk({tag, "_epc_badv"}, {cp0_epc, cp0_badvaddr}, 0);
    endtask

    task automatic drive_vec(input vec_t v);
        @(negedge clk);
        lane_valid   = v.valid;
        lane_pc      = {v.pc1, v.pc0};
        lane_bd      = v.bd;
        lane_cause   = {v.c1, v.c0};
        lane_mem_wen = v.wen;
        lane_badaddr = {v.a1, v.a0};
        exl          = v.exl;
        use_bev      = v.bev;
        cp0_ebase    = v.ebase;
        #1;
        chk("lane_kill", lane_kill, v.kill);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        lane_valid = '0;
        lane_cause = '0;
    endtask

    task automatic wait_redirect(output bit ok);
        int nfl = 0;
        int lat = -1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (redirect_valid) begin
                ok  = 1'b1;
                lat = i;
                break;
            end
            if (flush) nfl++;
        end
        chk("redirect_seen", ok, 1);
        chk("flush_len", nfl, FLUSH);
        chk("redirect_latency", lat, FLUSH);
    endtask

    task automatic handshake();
        chk("redirect_pc", redirect_pc, exp_q[0].rpc);
        redirect_ready = 1'b1;
        @(posedge clk);
        #1;
        redirect_ready = 1'b0;
        chk("idle_after_ack", {commit_stall, redirect_valid, flush}, 0);
        void'(exp_q.pop_front());
    endtask

    // Scoreboard side: compare every CP0 pulse against the oldest pending expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_pulse = 1'b0;
        end else begin
            if (cp0_exp_en || cp0_exl_clean) begin
                chk("pulse_width", prev_pulse, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    mon_e = exp_q[0];
                    chk("exp_en", {cp0_exp_en, cp0_exl_clean}, {~mon_e.eret, mon_e.eret});
                    chk("badv_wen", cp0_badvaddr_wen, mon_e.bwen);
                    chk("asid_en", cp0_asid_en, mon_e.aen);
                    if (!mon_e.eret) begin
                        chk("code", cp0_code, mon_e.code);
                        chk("epc", cp0_epc, mon_e.epc);
                        chk("bd", cp0_bd, mon_e.ebd);
                    end
                    if (mon_e.bwen) chk("badvaddr", cp0_badvaddr, mon_e.badv);
                    if (mon_e.aen)  chk("asid", cp0_asid, mon_e.asid);
                end
            end
            prev_pulse = cp0_exp_en || cp0_exl_clean;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   ok;

        rst = 1'b1; lane_valid = '0; lane_pc = '0; lane_bd = '0; lane_cause = '0;
        lane_mem_wen = '0; lane_badaddr = '0; asid_if = 8'h11; asid_mem = 8'h5A;
        int_flag = '0; allow_interrupt = 1'b0; exl = 1'b0; cp0_ebase = 32'h8000_0000;
        use_iv = 1'b0; use_bev = 1'b0; epc_in = 32'h8000_2000; redirect_ready = 1'b0;

        // Scenario table
        v = def_vec(); v.valid = 2'b11; v.pc0 = 32'h8000_0ff0; v.pc1 = 32'h8000_1004; v.bd = 2'b10;
        v.c1 = cb(CAUSE_OV); v.kill = 2'b10; v.code = 5'h0c; v.epc = 32'h8000_1000; v.ebd = 1'b1;
        vecs.push_back(v);
        v = def_vec(); v.valid = 2'b11; v.pc0 = 32'h8000_3000; v.c0 = cb(CAUSE_DTLB_REFILL); v.wen = 2'b01;
        v.a0 = 32'h0040_0010; v.c1 = cb(CAUSE_SYS); v.kill = 2'b11; v.code = 5'h03; v.epc = 32'h8000_3000;
        v.bwen = 1'b1; v.badv = 32'h0040_0010; v.aen = 1'b1; v.asid = 8'h5A; v.rpc = 32'h8000_0000;
        vecs.push_back(v);
        v = def_vec(); v.valid = 2'b01; v.pc0 = 32'h8000_4000; v.c0 = cb(CAUSE_ERET); v.kill = 2'b11;
        v.eret = 1'b1; v.rpc = 32'h8000_2000;
        vecs.push_back(v);
        v = def_vec(); v.valid = 2'b01; v.pc0 = 32'h0040_1000; v.c0 = cb(CAUSE_ITLB_REFILL); v.exl = 1'b1;
        v.kill = 2'b11; v.code = 5'h02; v.epc = 32'h0040_1000; v.bwen = 1'b1; v.badv = 32'h0040_1000;
        v.aen = 1'b1; v.asid = 8'h11;
        vecs.push_back(v);
        v = def_vec(); v.valid = 2'b10; v.c0 = cb(CAUSE_SYS); v.pc1 = 32'h8000_5008; v.c1 = cb(CAUSE_RI);
        v.kill = 2'b10; v.code = 5'h0a; v.epc = 32'h8000_5008;
        vecs.push_back(v);
        v = def_vec(); v.valid = 2'b01; v.bev = 1'b1; v.pc0 = 32'hBFC0_0010; v.c0 = cb(CAUSE_ADE_DATA);
        v.a0 = 32'h0000_0003; v.kill = 2'b11; v.code = 5'h04; v.epc = 32'hBFC0_0010; v.bwen = 1'b1;
        v.badv = 32'h0000_0003; v.rpc = 32'hBFC0_0380;
        vecs.push_back(v);
        v = def_vec(); v.valid = 2'b01; v.pc0 = 32'h8000_6000; v.c0 = cb(CAUSE_MOD); v.wen = 2'b01;
        v.a0 = 32'h0040_2000; v.kill = 2'b11; v.code = 5'h01; v.epc = 32'h8000_6000; v.bwen = 1'b1;
        v.badv = 32'h0040_2000; v.aen = 1'b1; v.asid = 8'h5A;
        vecs.push_back(v);
        v = def_vec(); v.valid = 2'b11; v.pc1 = 32'h8000_7004;
        v.c1 = cb(CAUSE_BP) | cb(CAUSE_OV) | cb(CAUSE_MOD); v.kill = 2'b10; v.code = 5'h09; v.epc = 32'h8000_7004;
        vecs.push_back(v);
        v = def_vec(); v.valid = 2'b01; v.pc0 = 32'h0000_0002;
        v.c0 = cb(CAUSE_ADEL_IF) | cb(CAUSE_ITLB_REFILL) | cb(CAUSE_SYS); v.kill = 2'b11; v.code = 5'h04;
        v.epc = 32'h0000_0002; v.bwen = 1'b1; v.badv = 32'h0000_0002;
        vecs.push_back(v);
        v = def_vec(); v.valid = 2'b01; v.pc0 = 32'h0000_0000; v.bd = 2'b01; v.c0 = cb(CAUSE_CPU);
        v.kill = 2'b11; v.code = 5'h0b; v.epc = 32'hFFFF_FFFC; v.ebd = 1'b1;
        vecs.push_back(v);
        v = def_vec(); v.valid = 2'b01; v.ebase = 32'hFFFF_F123; v.pc0 = 32'h8000_8000; v.c0 = cb(CAUSE_SYS);
        v.kill = 2'b11; v.code = 5'h08; v.epc = 32'h8000_8000; v.rpc = 32'hBFFF_F180;
        vecs.push_back(v);
        v = def_vec(); v.valid = 2'b10; v.pc1 = 32'h8000_9000; v.c1 = cb(CAUSE_DTLB_INVALID);
        v.a1 = 32'h7FFF_0000; v.kill = 2'b10; v.code = 5'h02; v.epc = 32'h8000_9000; v.bwen = 1'b1;
        v.badv = 32'h7FFF_0000; v.aen = 1'b1; v.asid = 8'h5A;
        vecs.push_back(v);
        v = def_vec(); v.valid = 2'b10; v.bev = 1'b1; v.pc1 = 32'h8000_a004; v.c1 = cb(CAUSE_DTLB_REFILL);
        v.a1 = 32'h0000_1000; v.kill = 2'b10; v.code = 5'h02; v.epc = 32'h8000_a004; v.bwen = 1'b1;
        v.badv = 32'h0000_1000; v.aen = 1'b1; v.asid = 8'h5A; v.rpc = 32'hBFC0_0200;
        vecs.push_back(v);

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive_vec(vecs[i]);
            wait_redirect(ok);
            handshake();
        end

        // Interrupt: sampled int_flag becomes a cause one cycle later
        @(negedge clk);
        int_flag = 8'h04; allow_interrupt = 1'b1; use_iv = 1'b1; exl = 1'b0; use_bev = 1'b0;
        cp0_ebase = 32'h8000_0000; lane_valid = 2'b01; lane_pc = {32'h0, 32'h8000_b000};
        lane_bd = '0; lane_cause = '0;
        #1;
        chk("int_not_yet", lane_kill, 0);
        v = def_vec(); v.kill = 2'b11; v.code = 5'h00; v.epc = 32'h8000_b000; v.rpc = 32'h8000_0200;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        chk("int_kill", lane_kill, 2'b11);
        @(posedge clk);
        #1;
        int_flag = '0; lane_valid = '0; use_iv = 1'b0;
        wait_redirect(ok);
        handshake();

        // Interrupt needs a valid lane 0, and allow_interrupt
        @(negedge clk);
        int_flag = 8'h01; lane_valid = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        chk("int_lane1_only", {lane_kill, commit_stall}, 0);
        lane_valid = 2'b01; allow_interrupt = 1'b0;
        #1;
        chk("int_masked", {lane_kill, commit_stall}, 0);
        int_flag = '0; lane_valid = '0;
        @(posedge clk);
        #1;

        // Redirect stalled by fetch, new cause ignored, then reset mid-REDIRECT
        v = def_vec(); v.valid = 2'b01; v.pc0 = 32'h8000_c000; v.c0 = cb(CAUSE_SYS);
        v.kill = 2'b11; v.code = 5'h08; v.epc = 32'h8000_c000;
        drive_vec(v);
        wait_redirect(ok);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", redirect_valid, 1);
            chk("stall_pc", redirect_pc, 32'h8000_0180);
            chk("stall_no_pulse", cp0_exp_en, 0);
            if (i == 1) begin
                lane_valid = 2'b01;
                lane_cause = {cb(CAUSE_OV), cb(CAUSE_OV)};
                #1;
                chk("stall_no_kill", lane_kill, 0);
                chk("stall_busy", commit_stall, 1);
            end
            @(negedge clk);
        end
        rst = 1'b1; lane_valid = '0; lane_cause = '0;
        @(posedge clk);
        #1;
        check_all_zero("mid_rst");
        rst = 1'b0;
        void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        chk("post_rst_idle", {commit_stall, redirect_valid, cp0_exp_en}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
